// File: rtl/e2prom_rw_ctrl.sv
// -----------------------------------------------------------------------------
// e2prom_rw_ctrl
//   EEPROM write-then-readback self-test sequencer. Sits directly upstream of
//   the I2C driver and runs one transaction at a time over its exec/done
//   handshake. Phase 1 writes BYTE_NUM bytes with data = address[7:0]. Phase 2
//   reads the same addresses back and compares every byte. Runs on the
//   driver's dri_clk, so there is no clock-domain crossing.
//
// Ports
//   clk         in   block clock (driver dri_clk), rising edge
//   rst         in   synchronous active-high reset
//   i2c_done    in   one-cycle pulse: driver finished the transaction
//   i2c_ack     in   1 = slave NACK, sampled with i2c_done
//   i2c_data_r  in   read data, valid with i2c_done on a read
//   i2c_exec    out  one-cycle transaction start pulse
//   i2c_rh_wl   out  1 = read, 0 = write; held from exec until done
//   i2c_addr    out  EEPROM byte address; held from exec until done
//   i2c_data_w  out  write data; held from exec until done
//   rw_done     out  sticky end-of-test flag (cleared only by rst)
//   rw_result   out  1 = pass, valid while rw_done = 1
//   err_cnt     out  failed-byte count (mismatch, NACK, timeout), saturating
//
// States
//   S_PWRUP   | wait START_DLY cycles after reset
//   S_WR_REQ  | load write address/data, fire exec
//   S_WR_WAIT | wait for done or timeout on a write
//   S_WR_GAP  | idle WR_GAP cycles for the EEPROM internal write
//   S_RD_REQ  | load read address, fire exec
//   S_RD_WAIT | wait for done or timeout on a read, compare data
//   S_FINISH  | latch rw_done / rw_result
//   S_HOLD    | terminal, everything frozen until rst
// -----------------------------------------------------------------------------
module e2prom_rw_ctrl #(
  parameter int unsigned BYTE_NUM   = 256,
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter int unsigned START_DLY  = 1000,
  parameter int unsigned WR_GAP     = 1250,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  output logic        rw_done,
  output logic        rw_result,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CNT_MAX_A = (START_DLY > WR_GAP) ? START_DLY : WR_GAP;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
  localparam int          CNT_W     = $clog2(CNT_MAX + 2);

  // Terminal counts. A zero delay still costs one cycle in its state.
  localparam logic [CNT_W-1:0] DLY_TC = CNT_W'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_TC = CNT_W'(TIMEOUT);
  localparam logic [16:0]      LAST_IDX = 17'(BYTE_NUM - 1);

  typedef enum logic [2:0] {
    S_PWRUP   = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_GAP  = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_FINISH  = 3'd6,
    S_HOLD    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      idx_q, idx_d;
  logic             exec_q, exec_d;
  logic             rh_wl_q, rh_wl_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_w_q, data_w_d;
  logic             done_q, done_d;
  logic             result_q, result_d;
  logic [7:0]       err_q, err_d;
  logic             tmo_q, tmo_d;

  logic [15:0]      cur_addr;
  logic [7:0]       err_plus;

  // 16-bit add: the address wraps from FFFF to 0000 by construction.
  assign cur_addr = START_ADDR + idx_q[15:0];
  assign err_plus = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_PWRUP;
      cnt_q    <= '0;
      idx_q    <= '0;
      exec_q   <= 1'b0;
      rh_wl_q  <= 1'b0;
      addr_q   <= START_ADDR;
      data_w_q <= 8'h00;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      err_q    <= 8'h00;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      exec_q   <= exec_d;
      rh_wl_q  <= rh_wl_d;
      addr_q   <= addr_d;
      data_w_q <= data_w_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    exec_d   = 1'b0;
    rh_wl_d  = rh_wl_q;
    addr_d   = addr_q;
    data_w_d = data_w_q;
    done_d   = done_q;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == DLY_TC) begin
          cnt_d   = '0;
          state_d = S_WR_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WR_REQ, S_RD_REQ: begin
        rh_wl_d  = (state_q == S_RD_REQ);
        addr_d   = cur_addr;
        data_w_d = cur_addr[7:0];
        exec_d   = 1'b1;
        cnt_d    = '0;
        state_d  = (state_q == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
      end

      // The first WAIT cycle is the exec cycle with cnt_q = 0, so cnt_q is
      // the number of cycles since exec. Done wins over an expiring timer.
      S_WR_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) err_d = err_plus;
          cnt_d   = '0;
          state_d = S_WR_GAP;
        end else if (cnt_q == TMO_TC) begin
          err_d   = err_plus;
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WR_GAP: begin
        if (cnt_q == GAP_TC) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RD_REQ;
          end else begin
            idx_d   = idx_q + 17'd1;
            state_d = S_WR_REQ;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RD_WAIT: begin
        if (i2c_done) begin
          // NACK and data mismatch on the same byte count as one error.
          if (i2c_ack || (i2c_data_r != cur_addr[7:0])) err_d = err_plus;
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 17'd1;
            state_d = S_RD_REQ;
          end
        end else if (cnt_q == TMO_TC) begin
          err_d   = err_plus;
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FINISH: begin
        done_d   = 1'b1;
        result_d = (err_q == 8'h00) && !tmo_q;
        state_d  = S_HOLD;
      end

      S_HOLD: begin
        state_d = S_HOLD;
      end

      default: begin
        state_d = S_PWRUP;
      end
    endcase
  end

  assign i2c_exec   = exec_q;
  assign i2c_rh_wl  = rh_wl_q;
  assign i2c_addr   = addr_q;
  assign i2c_data_w = data_w_q;
  assign rw_done    = done_q;
  assign rw_result  = result_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_e2prom_rw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_e2prom_rw_ctrl
//   Bench for e2prom_rw_ctrl with a small I2C driver/EEPROM model. Expected
//   transaction lists, exec timing and final results come from an arithmetic
//   model of the test sequence.
// -----------------------------------------------------------------------------
module tb_e2prom_rw_ctrl;

  localparam int          N   = 4;
  localparam logic [15:0] SA  = 16'h00FE;
  localparam int          SD  = 5;
  localparam int          GAP = 8;
  localparam int          TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [7:0]  i2c_data_r = 8'h00;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic        rw_done;
  logic        rw_result;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  e2prom_rw_ctrl #(
    .BYTE_NUM  (N),
    .START_ADDR(SA),
    .START_DLY (SD),
    .WR_GAP    (GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_done  (i2c_done),
    .i2c_ack   (i2c_ack),
    .i2c_data_r(i2c_data_r),
    .i2c_exec  (i2c_exec),
    .i2c_rh_wl (i2c_rh_wl),
    .i2c_addr  (i2c_addr),
    .i2c_data_w(i2c_data_w),
    .rw_done   (rw_done),
    .rw_result (rw_result),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rh;
    logic [7:0]  dw;
    int          rel;
  } txn_t;

  typedef struct {
    string name;
    int    nack;
    int    bad;
    int    silent;
    bit    spur;
    int    execs;
    int    err;
    bit    res;
  } vec_t;

  txn_t obs[$];
  txn_t exp_q[$];
  logic [7:0] mem [int];

  int cfg_nack = -1, cfg_bad = -1, cfg_silent = -1, cfg_delay = 20;
  bit cfg_spur = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int rel = -1, pend = 0, spur_cnt = 0, cur_t = 0, done_rel = -1;
  bit outstanding = 1'b0, done_seen = 1'b0;
  logic [7:0]  rd;
  logic [15:0] ra;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Driver / EEPROM model: answers done cfg_delay cycles after exec,
  // echoes written bytes on reads, optionally NACKs, corrupts, stays silent,
  // or throws a stray done into the write gap.
  initial begin : drv
    forever begin
      @(negedge clk);
      i2c_done   = 1'b0;
      i2c_ack    = 1'b0;
      i2c_data_r = 8'($urandom);
      if (rst) begin
        rel = -1; pend = 0; spur_cnt = 0; outstanding = 1'b0;
        done_seen = 1'b0; done_rel = -1;
        obs.delete();
        mem.delete();
      end else begin
        rel++;
        if (spur_cnt > 0) begin
          spur_cnt--;
          if (spur_cnt == 0) begin
            i2c_done = 1'b1;
            i2c_ack  = 1'b1;
          end
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            i2c_done    = 1'b1;
            i2c_ack     = (cur_t == cfg_nack);
            outstanding = 1'b0;
            ra          = obs[cur_t].addr;
            if (!obs[cur_t].rh) begin
              mem[int'(ra)] = obs[cur_t].dw;
              if (cfg_spur) spur_cnt = 4;
            end else begin
              rd = mem.exists(int'(ra)) ? mem[int'(ra)] : 8'hC3;
              if (cur_t == cfg_bad) rd = (rd == 8'hAA) ? 8'h55 : 8'hAA;
              i2c_data_r = rd;
            end
          end
        end
        if (i2c_exec === 1'b1) begin
          chk("exec_while_outstanding", 64'(outstanding), 64'(0));
          obs.push_back('{i2c_addr, i2c_rh_wl, i2c_data_w, rel});
          cur_t       = obs.size() - 1;
          outstanding = 1'b1;
          if (cur_t != cfg_silent) pend = cfg_delay;
        end
        if (rw_done === 1'b1 && !done_seen) begin
          done_seen = 1'b1;
          done_rel  = rel;
        end
      end
    end
  end

  task automatic do_reset(input int cyc_n);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, rw_done, rw_result, err_cnt}),
        64'({1'b0, 1'b0, SA, 8'h00, 1'b0, 1'b0, 8'h00}));
    repeat (cyc_n - 1) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_scn(input int nack, input int bad, input int silent,
                           input int delay, input bit spur);
    cfg_nack   = nack;
    cfg_bad    = bad;
    cfg_silent = silent;
    cfg_delay  = delay;
    cfg_spur   = spur;
    do_reset(2);
  endtask

  task automatic finish_scn(input string nm, input bit use_tab, input int t_execs,
                            input int t_err, input bit t_res);
    int          t_exec;
    int          e_err;
    int          e_done;
    bit          e_res;
    int          w;
    logic [15:0] a;
    t_exec = SD + 1;
    e_err  = 0;
    e_done = -1;
    exp_q.delete();
    for (int t = 0; t < 2 * N; t++) begin
      a = SA + 16'(t % N);
      exp_q.push_back('{a, (t >= N), a[7:0], t_exec});
      if (t == cfg_silent) begin
        e_err++;
        e_done = t_exec + TMO + 2;
        break;
      end
      if (t == cfg_nack || (t >= N && t == cfg_bad)) e_err++;
      if (t == 2 * N - 1) e_done = t_exec + cfg_delay + 2;
      t_exec += cfg_delay + 2 + ((t < N) ? GAP : 0);
    end
    e_res = (e_err == 0);

    w = 0;
    while (!done_seen && w < 5000) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk({nm, "_done_reached"}, 64'(done_seen), 64'(1));
    repeat (300) @(negedge clk);
    #1;

    chk({nm, "_exec_count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs.size()) begin
        chk({nm, "_txn_fields"}, 64'({obs[i].addr, obs[i].rh, obs[i].dw}),
            64'({exp_q[i].addr, exp_q[i].rh, exp_q[i].dw}));
        chk({nm, "_txn_cycle"}, 64'(obs[i].rel), 64'(exp_q[i].rel));
      end
    end
    chk({nm, "_done_cycle"}, 64'(done_rel), 64'(e_done));
    chk({nm, "_done_sticky"}, 64'(rw_done), 64'(1));
    chk({nm, "_result"}, 64'(rw_result), 64'(e_res));
    chk({nm, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
    if (use_tab) begin
      chk({nm, "_tab_execs"}, 64'(obs.size()), 64'(t_execs));
      chk({nm, "_tab_err"}, 64'(err_cnt), 64'(t_err));
      chk({nm, "_tab_result"}, 64'(rw_result), 64'(t_res));
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[7];
    int   w;
    vecs[0] = '{"clean",       -1, -1, -1, 1'b0, 8, 0, 1'b1};
    vecs[1] = '{"bad_rd_0100", -1,  6, -1, 1'b0, 8, 1, 1'b0};
    vecs[2] = '{"nack_wr2",     1, -1, -1, 1'b0, 8, 1, 1'b0};
    vecs[3] = '{"silent_wr3",  -1, -1,  2, 1'b0, 3, 1, 1'b0};
    vecs[4] = '{"spur_gap",    -1, -1, -1, 1'b1, 8, 0, 1'b1};
    vecs[5] = '{"nack_bad_rd",  5,  5, -1, 1'b0, 8, 1, 1'b0};
    vecs[6] = '{"silent_rd4",  -1, -1,  7, 1'b0, 8, 1, 1'b0};

    for (int v = 0; v < 7; v++) begin
      start_scn(vecs[v].nack, vecs[v].bad, vecs[v].silent, 20, vecs[v].spur);
      finish_scn(vecs[v].name, 1'b1, vecs[v].execs, vecs[v].err, vecs[v].res);
    end

    // Reset while a read is outstanding, after an error has been counted.
    start_scn(1, -1, -1, 20, 1'b0);
    w = 0;
    while (obs.size() < 6 && w < 3000) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("midrst_reached_read", 64'(obs.size() >= 6), 64'(1));
    repeat (5) @(negedge clk);
    #1;
    chk("midrst_err_before", 64'(err_cnt), 64'(1));
    do_reset(1);
    finish_scn("midrst", 1'b1, 8, 1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      start_scn(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * N - 1)) : -1,
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(N, 2 * N - 1)) : -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * N - 1)) : -1,
                int'($urandom_range(1, 40)),
                1'($urandom_range(0, 1)));
      finish_scn("rand", 1'b0, 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
